// File: rtl/configurable_logic_decoder_if.sv
// Sample/result bundle for configurable_logic_decoder.
//   start        : one-cycle pulse, clears the table and (re)starts collection
//   in_valid/in_a/in_b/in_y : observed cell sample, transferred when in_ready=1
//   in_ready     : decoder is collecting samples
//   seen         : bit {A,B} set once that input combination has been captured
//   out_valid    : result fields are valid (held until the next start)
//   out_sel      : decoded SEL
//   out_match    : table matched an opcode
//   out_conflict : same {A,B} observed with two different Y values
//   out_timeout  : collection aborted because samples stopped arriving
interface configurable_logic_decoder_if;
  logic       start;
  logic       in_valid;
  logic       in_a;
  logic       in_b;
  logic       in_y;
  logic       in_ready;
  logic [3:0] seen;
  logic       out_valid;
  logic [2:0] out_sel;
  logic       out_match;
  logic       out_conflict;
  logic       out_timeout;

  // master: the side that drives samples and reads results
  modport master (
    output start, in_valid, in_a, in_b, in_y,
    input  in_ready, seen, out_valid, out_sel, out_match, out_conflict, out_timeout
  );

  // slave: the decoder
  modport slave (
    input  start, in_valid, in_a, in_b, in_y,
    output in_ready, seen, out_valid, out_sel, out_match, out_conflict, out_timeout
  );
endinterface

// File: rtl/configurable_logic_decoder.sv
// configurable_logic_decoder
// Recovers the 3-bit SEL of a configurable logic cell from observed (A,B,Y)
// samples. A 4-entry truth table (index {A,B}, value Y) is collected over a
// valid/ready stream and then matched against the fixed opcode map.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : configurable_logic_decoder_if.slave (sample stream + results)
// Result timing:
//   - out_match/out_sel/out_conflict/out_timeout are loaded on the edge that
//     enters DONE; out_valid follows one edge later, so the 4th distinct
//     sample accepted at edge N gives out_valid after edge N+2.
//   - Idle timeout fires on the TIMEOUT_CYCLES-th idle edge after the last
//     accepted sample.
module configurable_logic_decoder #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
  input logic                         clk,
  input logic                         rst_n,
  configurable_logic_decoder_if.slave bus
);

  typedef enum logic [1:0] {IDLE, COLLECT, RESOLVE, DONE} state_t;

  // Opcode map, entry i = truth table of SEL i (bit index {A,B}).
  localparam logic [7:0][3:0] CODES = {
    4'b1100,  // 7 BUF A
    4'b0011,  // 6 NOT A
    4'b1001,  // 5 XNOR
    4'b0001,  // 4 NOR
    4'b0111,  // 3 NAND
    4'b0110,  // 2 XOR
    4'b1110,  // 1 OR
    4'b1000   // 0 AND
  };

  state_t           state, state_n;
  logic [3:0]       tbl;
  logic [3:0]       seen_q;
  logic [CNT_W-1:0] cnt;
  logic             in_ready_q;
  logic             out_valid_q;
  logic [2:0]       out_sel_q;
  logic             out_match_q;
  logic             out_conflict_q;
  logic             out_timeout_q;

  logic       xfer;
  logic [1:0] idx;
  logic [3:0] idx_oh;
  logic       dup_bad;
  logic       set_conflict;
  logic       set_timeout;
  logic       hit;
  logic [2:0] hit_sel;

  assign xfer    = bus.in_valid && in_ready_q;
  assign idx     = {bus.in_a, bus.in_b};
  assign idx_oh  = 4'b0001 << idx;
  // A repeat of an already captured {A,B} with a different Y means the
  // observed cell is not a fixed function (or the samples are corrupt).
  assign dup_bad = xfer && seen_q[idx] && (tbl[idx] != bus.in_y);

  // Table lookup against the opcode map; codes are distinct so at most one hits.
  always_comb begin
    hit     = 1'b0;
    hit_sel = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (!hit && tbl == CODES[i]) begin
        hit     = 1'b1;
        hit_sel = 3'(i);
      end
    end
  end

  // Next-state logic. start overrides everything.
  always_comb begin
    state_n      = state;
    set_conflict = 1'b0;
    set_timeout  = 1'b0;
    if (bus.start) begin
      state_n = COLLECT;
    end else begin
      case (state)
        IDLE: state_n = IDLE;
        COLLECT: begin
          if (xfer) begin
            if (dup_bad) begin
              state_n      = DONE;
              set_conflict = 1'b1;
            end else if ((seen_q | idx_oh) == 4'hF) begin
              state_n = RESOLVE;
            end
          end else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            // this idle edge brings the counter to TIMEOUT_CYCLES
            state_n     = DONE;
            set_timeout = 1'b1;
          end
        end
        RESOLVE: state_n = DONE;
        DONE:    state_n = DONE;
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tbl            <= '0;
      seen_q         <= '0;
      cnt            <= '0;
      in_ready_q     <= 1'b0;
      out_valid_q    <= 1'b0;
      out_sel_q      <= '0;
      out_match_q    <= 1'b0;
      out_conflict_q <= 1'b0;
      out_timeout_q  <= 1'b0;
    end else begin
      in_ready_q <= (state_n == COLLECT);
      if (bus.start) begin
        // any sample presented with start is dropped
        tbl            <= '0;
        seen_q         <= '0;
        cnt            <= '0;
        out_valid_q    <= 1'b0;
        out_sel_q      <= '0;
        out_match_q    <= 1'b0;
        out_conflict_q <= 1'b0;
        out_timeout_q  <= 1'b0;
      end else begin
        out_valid_q <= (state == DONE);
        if (state == COLLECT) begin
          if (xfer) begin
            cnt <= '0;
            if (!dup_bad) begin
              tbl[idx]    <= bus.in_y;
              seen_q[idx] <= 1'b1;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        if (set_conflict) begin
          out_conflict_q <= 1'b1;
          out_match_q    <= 1'b0;
        end
        if (set_timeout) begin
          out_timeout_q <= 1'b1;
          out_match_q   <= 1'b0;
        end
        if (state == RESOLVE) begin
          out_match_q <= hit;
          out_sel_q   <= hit_sel;
        end
      end
    end
  end

  assign bus.in_ready     = in_ready_q;
  assign bus.seen         = seen_q;
  assign bus.out_valid    = out_valid_q;
  assign bus.out_sel      = out_sel_q;
  assign bus.out_match    = out_match_q;
  assign bus.out_conflict = out_conflict_q;
  assign bus.out_timeout  = out_timeout_q;

endmodule

// File: tb/tb_configurable_logic_decoder.sv
module tb_configurable_logic_decoder;

  typedef struct packed {
    logic [2:0] sel;
    logic       match;
    logic       conflict;
    logic       timeout;
  } exp_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  exp_t expq[$];
  logic prev_valid;

  configurable_logic_decoder_if bus();

  configurable_logic_decoder #(.TIMEOUT_CYCLES(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reference cell behaviour, written from the gate names.
  function automatic logic ref_y(input int sel, input logic a, input logic b);
    case (sel)
      0: return a & b;
      1: return a | b;
      2: return a ^ b;
      3: return ~(a & b);
      4: return ~(a | b);
      5: return ~(a ^ b);
      6: return ~a;
      default: return a;
    endcase
  endfunction

  // Monitor: compare result fields on each rising out_valid.
  always @(negedge clk) begin
    if (bus.out_valid && !prev_valid) begin
      if (expq.size() == 0) begin
        chk("unexpected_result", 8'd1, 8'd0);
      end else begin
        exp_t e;
        e = expq.pop_front();
        chk("res_sel", 8'(bus.out_sel), 8'(e.sel));
        chk("res_match", 8'(bus.out_match), 8'(e.match));
        chk("res_conflict", 8'(bus.out_conflict), 8'(e.conflict));
        chk("res_timeout", 8'(bus.out_timeout), 8'(e.timeout));
      end
    end
    prev_valid <= bus.out_valid;
  end

  // All tasks start and end 1ns after a rising edge.
  task automatic pulse_start();
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic send(input logic a, input logic b, input logic y);
    bus.in_valid = 1'b1; bus.in_a = a; bus.in_b = b; bus.in_y = y;
    chk("in_ready_before_send", 8'(bus.in_ready), 8'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_valid(input int limit);
    int n;
    n = 0;
    while (!bus.out_valid && n < limit) begin
      @(posedge clk); #1;
      n++;
    end
    chk("out_valid_within_bound", 8'(bus.out_valid), 8'd1);
    @(posedge clk); #1;  // let the monitor see it
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_in_ready"}, 8'(bus.in_ready), 8'd0);
    chk({tag, "_seen"}, 8'(bus.seen), 8'd0);
    chk({tag, "_out_valid"}, 8'(bus.out_valid), 8'd0);
    chk({tag, "_outs"}, {3'd0, bus.out_sel, bus.out_match, bus.out_conflict, bus.out_timeout}, 8'd0);
  endtask

  initial begin
    logic [3:0] xor_ab [5];
    logic [3:0] xor_seen [5];
    checks = 0; failures = 0; prev_valid = 1'b0;
    bus.start = 1'b0; bus.in_valid = 1'b0;
    bus.in_a = 1'b0; bus.in_b = 1'b0; bus.in_y = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_in_ready", 8'(bus.in_ready), 8'd0);

    // 1: sweep SEL, back-to-back samples, out_valid exactly 2 edges later
    for (int s = 0; s < 8; s++) begin
      pulse_start();
      expq.push_back('{sel: 3'(s), match: 1'b1, conflict: 1'b0, timeout: 1'b0});
      for (int k = 0; k < 4; k++) begin
        logic a, b;
        a = k[1]; b = k[0];
        send(a, b, ref_y(s, a, b));
      end
      chk("sweep_seen", 8'(bus.seen), 8'hF);
      chk("sweep_valid_n1", 8'(bus.out_valid), 8'd0);
      @(posedge clk); #1;
      chk("sweep_valid_n1b", 8'(bus.out_valid), 8'd0);
      @(posedge clk); #1;
      chk("sweep_valid_n2", 8'(bus.out_valid), 8'd1);
      @(posedge clk); #1;
    end

    // 2: XOR with duplicate and idle gaps, seen walks up
    xor_ab   = '{4'd3, 4'd3, 4'd0, 4'd2, 4'd1};
    xor_seen = '{4'b1000, 4'b1000, 4'b1001, 4'b1101, 4'b1111};
    pulse_start();
    expq.push_back('{sel: 3'd2, match: 1'b1, conflict: 1'b0, timeout: 1'b0});
    for (int k = 0; k < 5; k++) begin
      logic [3:0] ab;
      ab = xor_ab[k];
      send(ab[1], ab[0], ab[1] ^ ab[0]);
      chk("xor_seen", 8'(bus.seen), 8'(xor_seen[k]));
      if (k < 4) begin
        @(posedge clk); #1;
      end
    end
    wait_valid(10);

    // 3: conflicting Y for the same {A,B}
    pulse_start();
    expq.push_back('{sel: 3'd0, match: 1'b0, conflict: 1'b1, timeout: 1'b0});
    send(1'b1, 1'b0, 1'b1);
    send(1'b1, 1'b0, 1'b0);
    chk("conflict_ready_low", 8'(bus.in_ready), 8'd0);
    chk("conflict_seen", 8'(bus.seen), 8'b0100);
    wait_valid(10);
    chk("conflict_seen_held", 8'(bus.seen), 8'b0100);

    // start with a simultaneous transfer: sample dropped, table cleared
    pulse_start();
    send(1'b0, 1'b1, 1'b1);
    bus.in_valid = 1'b1; bus.in_a = 1'b1; bus.in_b = 1'b1; bus.in_y = 1'b1;
    pulse_start();
    bus.in_valid = 1'b0;
    chk("start_xfer_seen", 8'(bus.seen), 8'd0);
    chk("start_xfer_ready", 8'(bus.in_ready), 8'd1);

    // 4: idle timeout 8 edges after the last transfer
    pulse_start();
    expq.push_back('{sel: 3'd0, match: 1'b0, conflict: 1'b0, timeout: 1'b1});
    send(1'b0, 1'b0, 1'b0);
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      if (k < 8) chk("timeout_early", 8'(bus.out_timeout), 8'd0);
    end
    chk("timeout_at_8", 8'(bus.out_timeout), 8'd1);
    chk("timeout_ready_low", 8'(bus.in_ready), 8'd0);
    wait_valid(5);
    chk("timeout_ready_after", 8'(bus.in_ready), 8'd0);

    // 5: constant-0 table has no opcode
    pulse_start();
    expq.push_back('{sel: 3'd0, match: 1'b0, conflict: 1'b0, timeout: 1'b0});
    for (int k = 0; k < 4; k++) begin
      logic a, b;
      a = k[1]; b = k[0];
      send(a, b, 1'b0);
    end
    wait_valid(10);

    // 6: async reset mid-collection, then NOR, then start during DONE
    pulse_start();
    send(1'b0, 1'b0, 1'b1);
    send(1'b1, 1'b1, 1'b0);
    chk("pre_reset_seen", 8'(bus.seen), 8'b1001);
    #2 rst_n = 1'b0;
    #1 check_all_zero("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    pulse_start();
    chk("post_reset_seen", 8'(bus.seen), 8'd0);
    expq.push_back('{sel: 3'd4, match: 1'b1, conflict: 1'b0, timeout: 1'b0});
    for (int k = 3; k >= 0; k--) begin
      logic a, b;
      a = k[1]; b = k[0];
      send(a, b, ref_y(4, a, b));
    end
    wait_valid(10);
    chk("done_valid_held", 8'(bus.out_valid), 8'd1);
    pulse_start();
    chk("start_in_done_valid", 8'(bus.out_valid), 8'd0);
    chk("start_in_done_match", 8'(bus.out_match), 8'd0);
    chk("start_in_done_seen", 8'(bus.seen), 8'd0);
    // fall back to idle before the idle timer fires
    rst_n = 1'b0;
    #1 rst_n = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_empty", 8'(expq.size()), 8'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
